// File: rtl/fifo_ctrl16.sv
// fifo_ctrl16: push/pop controller driving a 16x8 dual-port sync RAM (no data storage); rd_valid one cycle after an accepted pop.
// Optional sticky overflow/underflow flags are built only when FIFO_CTRL16_ERR_EN is defined.
module fifo_ctrl16 #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int ADDR     = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             err_clr,
  output logic             ram_wr,
  output logic [ADDR-1:0]  ram_wraddr,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_rd,
  output logic [ADDR-1:0]  ram_rdaddr,
  output logic             rd_valid,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AF_C    = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] AE_C    = (ADDR+1)'(AE_LEVEL);

  logic [ADDR:0] wptr;
  logic [ADDR:0] rptr;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Strobes are gated by rst so nothing reaches the RAM while reset is held.
  assign ram_wr     = push & ~full & rst;
  assign ram_rd     = pop & ~empty & rst;
  assign ram_wraddr = wptr[ADDR-1:0];
  assign ram_rdaddr = rptr[ADDR-1:0];
  assign ram_din    = push_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= ram_rd;
      if (ram_wr) wptr <= wptr + 1'b1;
      if (ram_rd) rptr <= rptr + 1'b1;
      case ({ram_wr, ram_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_CTRL16_ERR_EN
  // A new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)  overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (pop & empty)  underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: doc/fifo_ctrl16.md
# fifo_ctrl16

Synchronous FIFO controller that sits directly upstream of the 16x8 dual-port synchronous RAM (`dualsyn16`). It turns push/pop requests into the RAM's `wr`/`rd` strobes, `wraddr`/`rdaddr` addresses and `din`, and tracks occupancy and full/empty/threshold flags. It also flags the cycle when RAM read data is valid. The RAM itself stays a separate instance; this block holds no data storage.

## Interface
Parameters:
- `DEPTH`, 16, number of RAM entries; must equal 2**`ADDR`
- `WIDTH`, 8, data width
- `ADDR`, 4, RAM address width
- `AF_LEVEL`, 14, `almost_full` asserts when count >= `AF_LEVEL`
- `AE_LEVEL`, 2, `almost_empty` asserts when count <= `AE_LEVEL`

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `push`  in  1  write request
- `push_data`  in  WIDTH  data to write
- `pop`  in  1  read request
- `err_clr`  in  1  clears the sticky error flags
- `ram_wr`  out  1  drives RAM `wr`
- `ram_wraddr`  out  ADDR  drives RAM `wraddr`
- `ram_din`  out  WIDTH  drives RAM `din`
- `ram_rd`  out  1  drives RAM `rd`
- `ram_rdaddr`  out  ADDR  drives RAM `rdaddr`
- `rd_valid`  out  1  RAM `dout` holds popped data this cycle
- `count`  out  ADDR+1  occupancy, 0..DEPTH
- `full`, `empty`, `almost_full`, `almost_empty`  out  1  status flags
- `overflow`, `underflow`  out  1  sticky error flags

## Operation
- State:
  - `wptr` and `rptr`, each ADDR+1 bits
  - `count`, ADDR+1 bits
  - `rd_valid` register
  - `overflow` and `underflow` registers
- Flags are decoded combinationally from registered `count`:
  - `full` = (count == DEPTH)
  - `empty` = (count == 0)
  - `almost_full` = (count >= AF_LEVEL)
  - `almost_empty` = (count <= AE_LEVEL)
- Accepted push: `ram_wr = push & ~full & rst`. When accepted, `wptr` increments.
- Accepted pop: `ram_rd = pop & ~empty & rst`. When accepted, `rptr` increments.
- `ram_wraddr = wptr[ADDR-1:0]`, `ram_rdaddr = rptr[ADDR-1:0]`, `ram_din = push_data`. All three are combinational pass-through.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - both accepted, or neither: unchanged
- Pointer wrap: low ADDR bits roll from 15 to 0 and the MSB toggles. `full`/`empty` are derived from `count`, not from pointer compare.
- Full plus push: the push is rejected, even if a pop is accepted in the same cycle. The pop proceeds and count goes to 15.
- Empty plus pop: the pop is rejected, even if a push is accepted in the same cycle. No write-to-read bypass; the push proceeds and count goes to 1.
- Rejected requests change no pointer or count.

## Timing
- Reset (rst=0, asynchronous): `wptr`=0, `rptr`=0, `count`=0, `rd_valid`=0, `overflow`=0, `underflow`=0.
  - Resulting outputs: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0.
  - `ram_wr`=0 and `ram_rd`=0 regardless of requests.
  - Address outputs are 0.
- Reset mid-operation discards all contents immediately. No RAM strobes are issued while `rst`=0.
- Write latency: `ram_wr` and address are presented in the request cycle. The RAM captures on that cycle's rising edge.
- Read latency:
  - `rd_valid` is the registered `ram_rd`, so it is high in the cycle after an accepted pop.
  - RAM `dout` is valid in that same cycle.
  - Back-to-back pops give back-to-back `rd_valid`.
- Flags and `count` reflect accepted operations one cycle after the request edge.
- Writing and reading the same address in one cycle cannot occur with valid data: it requires count 0 (pop rejected) or 16 (push rejected).

## Configuration
- Macro `FIFO_CTRL16_ERR_EN`.
- Defined:
  - `overflow` is set on any clock edge with `push & full`.
  - `underflow` is set on any clock edge with `pop & empty`.
  - Both are sticky, cleared by reset or by `err_clr`=1 at a clock edge.
  - If a set condition and `err_clr` occur on the same edge, set wins.
- Undefined: `overflow` and `underflow` are tied to 0, `err_clr` is ignored, and no error registers are synthesized.

## Test plan
- Reset: drive rst=0 mid-stream with push=1 → `count`=0, `empty`=1, `ram_wr`=0 immediately; after release, `wptr`/`rptr` restart at address 0.
- Fill: 16 pushes of data 0x10..0x1F → `ram_wraddr` steps 0..15, `count`=16, `full`=1, `almost_full` first high at count 14; a 17th push gives `ram_wr`=0 and, with the macro defined, `overflow`=1.
- Drain: 16 pops after the fill → `ram_rdaddr` steps 0..15, `rd_valid` high the cycle after each pop, RAM `dout` = 0x10..0x1F in order, then `empty`=1; a 17th pop gives `ram_rd`=0 and `underflow`=1.
- Simultaneous: at count=5, push+pop for 20 cycles → `count` stays 5, pointers wrap past 15→0, and data order is preserved.
- Boundaries: at count=16, push+pop → pop only, count=15. At count=0, push+pop → push only, count=1, `rd_valid`=0.
- Error clear: with `overflow`=1, pulse `err_clr` → 0 next cycle. `err_clr` together with `push & full` → stays 1.
